// File: rtl/cu_run_controller_if.sv
// CAR-side run-control bundle: sequencing field and halt bit in,
// start enable, step mode and next-instruction stimulus out.
interface cu_run_controller_if;
   logic [1:0] i_control_word_car;
   logic       i_ctrl_halt;
   logic       o_cpu_start;
   logic       o_step_execution;
   logic       o_next_instr_stimulus;

   modport slave (
      input  i_control_word_car,
      input  i_ctrl_halt,
      output o_cpu_start,
      output o_step_execution,
      output o_next_instr_stimulus
   );

   modport master (
      output i_control_word_car,
      output i_ctrl_halt,
      input  o_cpu_start,
      input  o_step_execution,
      input  o_next_instr_stimulus
   );
endinterface

// File: rtl/cu_run_controller.sv
// Run/step controller: conditions the board inputs, sequences IDLE/RUN/STEP_WAIT/HALTED
// and counts instructions retired through the fetch-release condition.
module cu_run_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_btn_start,
   input  logic                 i_btn_next,
   input  logic                 i_sw_step,
   cu_run_controller_if.slave   car,
   output logic [1:0]           o_state,
   output logic [CNT_W-1:0]     o_instr_count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam int CH_START = 0;
   localparam int CH_NEXT  = 1;
   localparam int CH_STEP  = 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_STEP_WAIT = 2'd2,
      ST_HALTED    = 2'd3
   } state_e;

   logic [2:0]       raw_s;
   logic [2:0]       sync1_q;
   logic [2:0]       sync2_q;
   logic [2:0]       deb_q, deb_d;
   logic [DW-1:0]    cnt_q [3];
   logic [DW-1:0]    cnt_d [3];
   logic [1:0]       deb_dly_q;
   logic [1:0]       press_q, press_d;
   logic             step_q, step_d;

   state_e           state_q, state_d;
   logic             cpu_start_q, cpu_start_d;
   logic             stim_q, stim_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             release_s;
   logic             start_p_s;
   logic             next_p_s;

   assign raw_s = {i_sw_step, i_btn_next, i_btn_start};

   // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive differing samples
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         deb_d[i] = deb_q[i];
         cnt_d[i] = {DW{1'b0}};
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync2_q[i];
               cnt_d[i] = {DW{1'b0}};
            end else begin
               cnt_d[i] = cnt_q[i] + DW'(1);
            end
         end else begin
            cnt_d[i] = {DW{1'b0}};
         end
      end
      press_d = deb_q[1:0] & ~deb_dly_q;
      step_d  = deb_q[CH_STEP];
   end

   // Input conditioning registers: synchronizers, debounce state, press pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q   <= 3'b000;
         sync2_q   <= 3'b000;
         deb_q     <= 3'b000;
         deb_dly_q <= 2'b00;
         press_q   <= 2'b00;
         step_q    <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= {DW{1'b0}};
         end
      end else begin
         sync1_q   <= raw_s;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q[1:0];
         press_q   <= press_d;
         step_q    <= step_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign start_p_s = press_q[CH_START];
   assign next_p_s  = press_q[CH_NEXT];

   // Same release condition the CAR uses to leave the end-of-instruction state
   assign release_s = (car.i_control_word_car == 2'b11) && !car.i_ctrl_halt &&
                      (!step_q || stim_q);

   // Next-state and output logic of the run-control FSM
   always_comb begin
      state_d     = state_q;
      cpu_start_d = cpu_start_q;
      stim_d      = 1'b0;
      count_d     = count_q;

      case (state_q)
         ST_IDLE: begin
            cpu_start_d = 1'b0;
            if (start_p_s) begin
               state_d     = ST_RUN;
               cpu_start_d = 1'b1;
               count_d     = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            cpu_start_d = 1'b1;
            if (release_s) begin
               count_d = count_q + CNT_W'(1);
            end else begin
               count_d = count_q;
            end
            if ((car.i_control_word_car == 2'b11) && car.i_ctrl_halt) begin
               state_d = ST_HALTED;
            end else if ((car.i_control_word_car == 2'b11) && step_q && !stim_q) begin
               state_d = ST_STEP_WAIT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_STEP_WAIT: begin
            cpu_start_d = 1'b1;
            // A switch drop wins over a simultaneous next press: the CAR auto-fetches
            if (!step_q) begin
               state_d = ST_RUN;
            end else if (next_p_s) begin
               state_d = ST_RUN;
               stim_d  = 1'b1;
            end else begin
               state_d = ST_STEP_WAIT;
            end
         end
         ST_HALTED: begin
            cpu_start_d = 1'b1;
            state_d     = ST_HALTED;
         end
         default: begin
            state_d     = ST_IDLE;
            cpu_start_d = 1'b0;
         end
      endcase

      if (start_p_s && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         cpu_start_d = 1'b0;
         stim_d      = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // FSM state, run enable, stimulus pulse and retired-instruction counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         cpu_start_q <= 1'b0;
         stim_q      <= 1'b0;
         count_q     <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cpu_start_q <= cpu_start_d;
         stim_q      <= stim_d;
         count_q     <= count_d;
      end
   end

   assign car.o_cpu_start           = cpu_start_q;
   assign car.o_step_execution      = step_q;
   assign car.o_next_instr_stimulus = stim_q;
   assign o_state                   = state_q;
   assign o_instr_count             = count_q;

endmodule
